// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns EX_MEM load/store control into a
// req/ack bus transaction, stalls the pipeline and formats sub-word data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_cntl_MemRead,
    input  logic        MEM_cntl_MemWrite,
    input  logic [2:0]  MEM_funct,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_WriteData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_ReadMemData,
    output logic        stall,
    output logic        MEM_WB_bubble,
    output logic        access_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  funct_q;
    logic [1:0]  off_q;

    logic        access;
    logic        illegal;
    logic        in_idle;
    logic        in_busy;
    logic [1:0]  off;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign access  = MEM_cntl_MemRead | MEM_cntl_MemWrite;
    assign off     = MEM_ALUResult[1:0];
    assign in_idle = (state == IDLE) && !reset;
    assign in_busy = (state == BUSY) && !reset;

    always_comb begin
        case (MEM_funct)
            3'b000:  illegal = 1'b0;
            3'b100:  illegal = MEM_cntl_MemWrite;
            3'b001:  illegal = off[0];
            3'b101:  illegal = off[0] | MEM_cntl_MemWrite;
            3'b010:  illegal = |off;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        st_wdata = MEM_WriteData;
        st_wstrb = 4'b1111;
        case (MEM_funct[1:0])
            2'b00: begin
                st_wdata = {4{MEM_WriteData[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{MEM_WriteData[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // An illegal access is squashed: bubble MEM_WB but let the pipe advance.
    assign access_exc    = in_idle && access && illegal;
    assign stall         = (in_idle && access && !illegal) || in_busy;
    assign MEM_WB_bubble = (in_idle && access) || in_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            funct_q         <= 3'd0;
            off_q           <= 2'd0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            dmem_wstrb      <= 4'd0;
            MEM_ReadMemData <= 32'd0;
            bus_err         <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !illegal) begin
                        state      <= BUSY;
                        cnt        <= 8'd0;
                        funct_q    <= MEM_funct;
                        off_q      <= off;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_cntl_MemWrite;
                        dmem_addr  <= {MEM_ALUResult[31:2], 2'b00};
                        dmem_wdata <= MEM_cntl_MemWrite ? st_wdata : 32'd0;
                        dmem_wstrb <= MEM_cntl_MemWrite ? st_wstrb : 4'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack || cnt == CNT_LAST) begin
                        state           <= DONE;
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        dmem_addr       <= 32'd0;
                        dmem_wdata      <= 32'd0;
                        dmem_wstrb      <= 4'd0;
                        MEM_ReadMemData <= dmem_ack ? ld_data : 32'd0;
                        bus_err         <= !dmem_ack;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, randomized accesses
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr, mw;
    logic [2:0]  fn;
    logic [31:0] alu, wd;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] rmd;
    logic        stall, bubble, exc, berr;

    int checks = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .MEM_cntl_MemRead(mr),
        .MEM_cntl_MemWrite(mw),
        .MEM_funct(fn),
        .MEM_ALUResult(alu),
        .MEM_WriteData(wd),
        .dmem_req(req),
        .dmem_we(we),
        .dmem_addr(addr),
        .dmem_wdata(wdata),
        .dmem_wstrb(wstrb),
        .dmem_ack(ack),
        .dmem_rdata(rdata),
        .MEM_ReadMemData(rmd),
        .stall(stall),
        .MEM_WB_bubble(bubble),
        .access_exc(exc),
        .bus_err(berr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rd;
        logic        wr;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdv;
        int          waits;
        logic        ill;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  es;
        logic [31:0] er;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte-granular arithmetic view of the access rules.
    function automatic void model(
        input logic wr, input logic [2:0] f, input logic [31:0] a,
        input logic [31:0] d, input logic [31:0] rdv,
        output logic ill, output logic [31:0] ea, output logic [31:0] ew,
        output logic [3:0] es, output logic [31:0] er);
        int size, o;
        longint unsigned v, m;
        size = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd2) ? 4 : 2;
        o = int'(a % 4);
        ill = (f == 3'd3 || f == 3'd6 || f == 3'd7)
              || (wr && f >= 3'd4) || ((a % size) != 0);
        ea = a - o;
        ew = 0;
        for (int i = 0; i < 4; i++)
            ew = ew | (((d >> (8 * (i % size))) & 32'hFF) << (8 * i));
        es = wr ? 4'(((1 << size) - 1) << o) : 4'd0;
        m = (64'd1 << (8 * size)) - 1;
        v = (64'(rdv) >> (8 * o)) & m;
        if (f < 3'd2 && v >= (m + 1) / 2)
            v = v + (64'hFFFF_FFFF - m);
        er = 32'(v);
    endfunction

    // Called just after a rising edge with the DUT idle; returns the same way.
    task automatic run_txn(input string nm, input logic rd, input logic wr,
                           input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdv,
                           input int waits, input logic ill,
                           input logic [31:0] ea, input logic [31:0] ew,
                           input logic [3:0] es, input logic [31:0] er);
        int nbusy;
        mr = rd; mw = wr; fn = f; alu = a; wd = d; ack = 0;
        @(negedge clk);
        if (!rd && !wr) begin
            chk({nm, " nop stall"}, 32'(stall), 0);
            chk({nm, " nop bubble"}, 32'(bubble), 0);
            chk({nm, " nop req"}, 32'(req), 0);
            @(posedge clk); #1;
            return;
        end
        chk({nm, " c0 stall"}, 32'(stall), 32'(!ill));
        chk({nm, " c0 bubble"}, 32'(bubble), 1);
        chk({nm, " c0 exc"}, 32'(exc), 32'(ill));
        chk({nm, " c0 req"}, 32'(req), 0);
        @(posedge clk); #1;
        if (ill) begin
            mr = 0; mw = 0;
            @(negedge clk);
            chk({nm, " exc pulse"}, 32'(exc), 0);
            chk({nm, " ill req"}, 32'(req), 0);
            chk({nm, " ill stall"}, 32'(stall), 0);
            @(posedge clk); #1;
            return;
        end
        nbusy = (waits < 0) ? TMO : waits + 1;
        for (int k = 0; k < nbusy; k++) begin
            ack = (k == waits);
            rdata = (k == waits) ? rdv : $urandom;
            @(negedge clk);
            chk({nm, " busy req"}, 32'(req), 1);
            chk({nm, " busy we"}, 32'(we), 32'(wr));
            chk({nm, " addr"}, addr, ea);
            chk({nm, " wstrb"}, 32'(wstrb), 32'(es));
            if (wr) chk({nm, " wdata"}, wdata, ew);
            chk({nm, " busy stall"}, 32'(stall), 1);
            chk({nm, " busy bubble"}, 32'(bubble), 1);
            @(posedge clk); #1;
        end
        ack = 0;
        @(negedge clk);
        chk({nm, " done req"}, 32'(req), 0);
        chk({nm, " done stall"}, 32'(stall), 0);
        chk({nm, " done bubble"}, 32'(bubble), 0);
        chk({nm, " bus_err"}, 32'(berr), 32'(waits < 0));
        if (rd) chk({nm, " rdata"}, rmd, (waits < 0) ? 32'd0 : er);
        @(posedge clk); #1;
        mr = 0; mw = 0;
    endtask

    task automatic run_vec(input vec_t v);
        run_txn(v.nm, v.rd, v.wr, v.f, v.a, v.d, v.rdv, v.waits,
                v.ill, v.ea, v.ew, v.es, v.er);
    endtask

    initial begin
        vec_t vt[13];
        vec_t rv;
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        vec_t rv;
        logic ill;
        logic [31:0] ea, ew, er;
        logic [3:0] es;

        vt[0]  = '{"lw",   1, 0, 3'd2, 32'h100, 0, 32'hABCD1234, 0,
                   0, 32'h100, 0, 4'h0, 32'hABCD1234};
        vt[1]  = '{"lb",   1, 0, 3'd0, 32'h103, 0, 32'h80FF7F01, 1,
                   0, 32'h100, 0, 4'h0, 32'hFFFFFF80};
        vt[2]  = '{"lbu",  1, 0, 3'd4, 32'h103, 0, 32'h80FF7F01, 0,
                   0, 32'h100, 0, 4'h0, 32'h00000080};
        vt[3]  = '{"lh",   1, 0, 3'd1, 32'h102, 0, 32'h80FF7F01, 2,
                   0, 32'h100, 0, 4'h0, 32'hFFFF80FF};
        vt[4]  = '{"lhu",  1, 0, 3'd5, 32'h102, 0, 32'h80FF7F01, 0,
                   0, 32'h100, 0, 4'h0, 32'h000080FF};
        vt[5]  = '{"sb",   0, 1, 3'd0, 32'h201, 32'hA5, 0, 0,
                   0, 32'h200, 32'hA5A5A5A5, 4'b0010, 0};
        vt[6]  = '{"sh",   0, 1, 3'd1, 32'h202, 32'h1234, 0, 1,
                   0, 32'h200, 32'h12341234, 4'b1100, 0};
        vt[7]  = '{"sw",   0, 1, 3'd2, 32'h204, 32'hDEADBEEF, 0, 2,
                   0, 32'h204, 32'hDEADBEEF, 4'b1111, 0};
        vt[8]  = '{"lwmis", 1, 0, 3'd2, 32'h102, 0, 0, 0,
                   1, 0, 0, 4'h0, 0};
        vt[9]  = '{"shmis", 0, 1, 3'd1, 32'h301, 32'h55, 0, 0,
                   1, 0, 0, 4'h0, 0};
        vt[10] = '{"f011", 1, 0, 3'd3, 32'h100, 0, 0, 0,
                   1, 0, 0, 4'h0, 0};
        vt[11] = '{"sbu",  0, 1, 3'd4, 32'h100, 32'h77, 0, 0,
                   1, 0, 0, 4'h0, 0};
        vt[12] = '{"lw3w", 1, 0, 3'd2, 32'h108, 0, 32'h12345678, 3,
                   0, 32'h108, 0, 4'h0, 32'h12345678};

        reset = 1; mr = 0; mw = 0; fn = 0; alu = 0; wd = 0;
        ack = 0; rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req", 32'(req), 0);
        chk("rst addr", addr, 0);
        chk("rst strb", 32'(wstrb), 0);
        chk("rst rdata", rmd, 0);
        chk("rst stall", 32'(stall), 0);
        chk("rst berr", 32'(berr), 0);
        @(posedge clk); #1;
        reset = 0;

        foreach (vt[i]) run_vec(vt[i]);

        // Stray ack while idle must not start or complete anything.
        ack = 1; rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("idle ack stall", 32'(stall), 0);
        @(posedge clk); #1;
        ack = 0;
        @(negedge clk);
        chk("idle ack req", 32'(req), 0);
        chk("idle ack rdata", rmd, 32'h12345678);
        @(posedge clk); #1;

        run_txn("b2b1", 1, 0, 3'd2, 32'h400, 0, 32'h11112222, 2,
                0, 32'h400, 0, 4'h0, 32'h11112222);
        run_txn("b2b2", 1, 0, 3'd2, 32'h404, 0, 32'h33334444, 2,
                0, 32'h404, 0, 4'h0, 32'h33334444);

        run_txn("tmo", 1, 0, 3'd2, 32'h500, 0, 0, -1,
                0, 32'h500, 0, 4'h0, 0);
        @(negedge clk);
        chk("tmo berr pulse", 32'(berr), 0);
        @(posedge clk); #1;

        // Reset in the middle of a 3-wait load, then a late ack.
        mr = 1; fn = 3'd2; alu = 32'h600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; mr = 0;
        @(posedge clk); #1;
        reset = 0; ack = 1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstbusy req", 32'(req), 0);
        chk("rstbusy stall", 32'(stall), 0);
        chk("rstbusy bubble", 32'(bubble), 0);
        chk("rstbusy addr", addr, 0);
        chk("rstbusy rdata", rmd, 0);
        @(posedge clk); #1;
        ack = 0;
        @(negedge clk);
        chk("late ack req", 32'(req), 0);
        chk("late ack rdata", rmd, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 4);
            rv.rd = (sel <= 1);
            rv.wr = (sel == 2 || sel == 3);
            rv.f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) rv.f = 3'd2 & {1'b0, 2'($urandom)};
            rv.a = $urandom;
            rv.d = $urandom;
            rv.rdv = $urandom;
            rv.waits = $urandom_range(0, 3);
            model(rv.wr, rv.f, rv.a, rv.d, rv.rdv, ill, ea, ew, es, er);
            run_txn("rand", rv.rd, rv.wr, rv.f, rv.a, rv.d, rv.rdv,
                    rv.waits, ill, ea, ew, es, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
